id_imm_stage: RTL and testbench

//  IF/ID pipeline stage feeding the immediate extender. Registers each fetched instruction and its PC

---
 rtl/id_imm_stage.sv | 151 +++++++++++++++
 tb/tb_id_imm_stage.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/id_imm_stage.sv
// IF/ID pipeline stage: registers instruction + PC behind a 2-entry skid buffer and
// pre-slices the immediate fields and EXTOp so downstream sees only registered values.
module id_imm_stage #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] RST_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      iimm_shamt,
    output logic [11:0]     iimm,
    output logic [11:0]     simm,
    output logic [11:0]     bimm,
    output logic [19:0]     uimm,
    output logic [19:0]     jimm,
    output logic [5:0]      EXTOp
);

    localparam logic [5:0] EXT_CTRL_ITYPE_SHAMT = 6'b100000;
    localparam logic [5:0] EXT_CTRL_ITYPE       = 6'b010000;
    localparam logic [5:0] EXT_CTRL_STYPE       = 6'b001000;
    localparam logic [5:0] EXT_CTRL_BTYPE       = 6'b000100;
    localparam logic [5:0] EXT_CTRL_UTYPE       = 6'b000010;
    localparam logic [5:0] EXT_CTRL_JTYPE       = 6'b000001;

    function automatic logic [5:0] ext_decode(input logic [31:0] instr);
        logic [5:0] ext;
        ext = 6'b000000;
        unique case (instr[6:0])
            7'b0010011: begin
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
                    ext = EXT_CTRL_ITYPE_SHAMT;
                end else begin
                    ext = EXT_CTRL_ITYPE;
                end
            end
            7'b0000011, 7'b1100111: ext = EXT_CTRL_ITYPE;
            7'b0100011:             ext = EXT_CTRL_STYPE;
            7'b1100011:             ext = EXT_CTRL_BTYPE;
            7'b0110111, 7'b0010111: ext = EXT_CTRL_UTYPE;
            7'b1101111:             ext = EXT_CTRL_JTYPE;
            default:                ext = 6'b000000;
        endcase
        return ext;
    endfunction

    logic            main_v_q, main_v_d;
    logic            skid_v_q, skid_v_d;
    logic            in_ready_q;
    logic [31:0]     skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [31:0]     main_instr_q;
    logic [XLEN-1:0] main_pc_q;
    logic [5:0]      extop_q;

    logic            accept, main_free, load_main, load_skid, data_en;
    logic [31:0]     src_instr, new_instr;
    logic [XLEN-1:0] src_pc, new_pc;
    logic [5:0]      new_ext;

    always_comb begin
        accept    = in_valid & in_ready_q;
        main_free = !main_v_q | out_ready;
        main_v_d  = main_v_q;
        skid_v_d  = skid_v_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (main_free) begin
            // A full skid always refills main first to keep order.
            main_v_d  = skid_v_q | accept;
            load_main = skid_v_q | accept;
            skid_v_d  = skid_v_q & accept;
            load_skid = skid_v_q & accept;
        end else begin
            skid_v_d  = skid_v_q | accept;
            load_skid = accept;
        end

        src_instr = skid_v_q ? skid_instr_q : in_instr;
        src_pc    = skid_v_q ? skid_pc_q : in_pc;
        data_en   = flush | load_main;
        new_instr = flush ? RST_INSTR : src_instr;
        new_pc    = flush ? '0 : src_pc;
        new_ext   = flush ? 6'b000000 : ext_decode(src_instr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_v_q   <= main_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= !skid_v_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_instr_q <= RST_INSTR;
            skid_pc_q    <= '0;
        end else if (load_skid) begin
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
        end
    end

    // Fields are sliced from the next-state instruction so they are true register outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_instr_q <= RST_INSTR;
            main_pc_q    <= '0;
            extop_q      <= 6'b000000;
            iimm_shamt   <= RST_INSTR[24:20];
            iimm         <= RST_INSTR[31:20];
            simm         <= {RST_INSTR[31:25], RST_INSTR[11:7]};
            bimm         <= {RST_INSTR[31], RST_INSTR[7], RST_INSTR[30:25], RST_INSTR[11:8]};
            uimm         <= RST_INSTR[31:12];
            jimm         <= {RST_INSTR[31], RST_INSTR[19:12], RST_INSTR[20], RST_INSTR[30:21]};
        end else if (data_en) begin
            main_instr_q <= new_instr;
            main_pc_q    <= new_pc;
            extop_q      <= new_ext;
            iimm_shamt   <= new_instr[24:20];
            iimm         <= new_instr[31:20];
            simm         <= {new_instr[31:25], new_instr[11:7]};
            bimm         <= {new_instr[31], new_instr[7], new_instr[30:25], new_instr[11:8]};
            uimm         <= new_instr[31:12];
            jimm         <= {new_instr[31], new_instr[19:12], new_instr[20], new_instr[30:21]};
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_v_q;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;
    assign EXTOp     = extop_q;

endmodule

// File: tb/tb_id_imm_stage.sv
// Self-checking bench for id_imm_stage: directed scenarios plus random traffic
// against a queue-based reference model of the stage.
module tb_id_imm_stage;

    localparam logic [31:0] RST_INSTR = 32'h00000013;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;
    logic [4:0]  iimm_shamt;
    logic [11:0] iimm, simm, bimm;
    logic [19:0] uimm, jimm;
    logic [5:0]  EXTOp;

    always #5 clk = ~clk;

    id_imm_stage #(.XLEN(32), .RST_INSTR(RST_INSTR)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .iimm_shamt(iimm_shamt), .iimm(iimm), .simm(simm), .bimm(bimm),
        .uimm(uimm), .jimm(jimm), .EXTOp(EXTOp)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: an ordered queue of at most two held entries.
    logic [63:0] q[$];
    logic        m_ready;
    logic [31:0] m_instr;
    logic [5:0]  m_ext;

    function automatic logic [5:0] ref_ext(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) return 6'b100000;
        if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) return 6'b010000;
        if (op == 7'b0100011) return 6'b001000;
        if (op == 7'b1100011) return 6'b000100;
        if (op == 7'b0110111 || op == 7'b0010111) return 6'b000010;
        if (op == 7'b1101111) return 6'b000001;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ready = 1'b0;
        m_instr = RST_INSTR;
        m_ext   = 6'b0;
    endtask

    task automatic model_edge();
        logic acc;
        if (flush) begin
            q.delete();
            m_ready = 1'b1;
            m_instr = RST_INSTR;
            m_ext   = 6'b0;
        end else begin
            acc = in_valid && m_ready;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back({in_instr, in_pc});
            m_ready = (q.size() < 2);
            if (q.size() > 0) begin
                m_instr = q[0][63:32];
                m_ext   = ref_ext(m_instr);
            end
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e;
        check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check_eq("in_ready", 32'(in_ready), 32'(m_ready));
        check_eq("out_instr", out_instr, m_instr);
        check_eq("EXTOp", 32'(EXTOp), 32'(m_ext));
        if (q.size() > 0) begin
            e = m_instr;
            check_eq("out_pc", out_pc, q[0][31:0]);
            check_eq("iimm_shamt", 32'(iimm_shamt), 32'(e[24:20]));
            check_eq("iimm", 32'(iimm), 32'(e[31:20]));
            check_eq("simm", 32'(simm), 32'({e[31:25], e[11:7]}));
            check_eq("bimm", 32'(bimm), 32'({e[31], e[7], e[30:25], e[11:8]}));
            check_eq("uimm", 32'(uimm), 32'(e[31:12]));
            check_eq("jimm", 32'(jimm), 32'({e[31], e[19:12], e[20], e[30:21]}));
        end
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_instr"}, out_instr, RST_INSTR);
        check_eq({tag, "_pc"}, out_pc, 32'd0);
        check_eq({tag, "_ext"}, 32'(EXTOp), 32'd0);
    endtask

    logic [31:0] stream2[5];
    logic [5:0]  ext2[5];
    logic [6:0]  ops[10];
    logic [31:0] r;

    initial begin
        stream2 = '{32'h00301093, 32'h00112223, 32'h00000463, 32'h123450B7, 32'h0080006F};
        ext2    = '{6'b100000, 6'b001000, 6'b000100, 6'b000010, 6'b000001};
        ops     = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011};
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rstn = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // addi x1,x0,-1
        cycle(1'b1, 32'hFFF00093, 32'h0, 1'b1, 1'b0);
        check_eq("t1_iimm", 32'(iimm), 32'h00000FFF);
        check_eq("t1_ext", 32'(EXTOp), 32'h10);

        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, stream2[i], 32'(4 * (i + 1)), 1'b1, 1'b0);
            check_eq("t2_ext", 32'(EXTOp), 32'(ext2[i]));
            if (i == 3) check_eq("t2_uimm", 32'(uimm), 32'h12345);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Stall with out_ready low for three cycles.
        cycle(1'b1, 32'h00A00113, 32'h100, 1'b0, 1'b0);
        cycle(1'b1, 32'h00B00193, 32'h104, 1'b0, 1'b0);
        check_eq("t3_ready_full", 32'(in_ready), 32'd0);
        cycle(1'b1, 32'h00C00213, 32'h108, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with main and skid both full and an input offered.
        cycle(1'b1, 32'h00D00293, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h00E00313, 32'h204, 1'b0, 1'b0);
        cycle(1'b1, 32'h00F00393, 32'h208, 1'b0, 1'b1);
        check_eq("t4_valid", 32'(out_valid), 32'd0);
        check_eq("t4_ready", 32'(in_ready), 32'd1);
        check_eq("t4_ext", 32'(EXTOp), 32'd0);
        repeat (2) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // R-type: no immediate kind but fields are still sliced.
        cycle(1'b1, 32'h002081B3, 32'h300, 1'b1, 1'b0);
        check_eq("t5_ext", 32'(EXTOp), 32'd0);
        check_eq("t5_iimm", 32'(iimm), 32'h002);

        // Asynchronous reset in the middle of a stall.
        cycle(1'b1, 32'h01000413, 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 32'h01100493, 32'h404, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1 check_reset_state("t6_async");
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'h01200513, 32'h500, 1'b1, 1'b0);
        check_eq("t6_instr", out_instr, 32'h01200513);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 9)];
            cycle(1'($urandom_range(0, 3) != 0), r, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
        end
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
